// File: rtl/rdy_vld_if.sv
// Ready/valid point-to-point link: the source drives vld and data, the destination drives rdy.
interface rdy_vld_if #(
  parameter int DATA_W = 32
);
  logic              vld;
  logic              rdy;
  logic [DATA_W-1:0] data;

  modport src (output vld, output data, input rdy);
  modport dst (input vld, input data, output rdy);
endinterface

// File: rtl/rdy_vld_src_fifo.sv
// Source endpoint for rdy_vld_if: a local producer fills a first-word-fall-through FIFO
// that drains onto the link, with transfer and stall counters for debug.
module rdy_vld_src_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  rdy_vld_if.src                   x,
  input  logic                     push_vld,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     push_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         sent_cnt,
  output logic [CNT_W-1:0]         stall_cnt,
  input  logic                     clr_stats
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic              stall;

  // Handshake status depends only on registered level, never on x.rdy.
  assign push_rdy = (level != FULL_LVL);
  assign x.vld    = (level != '0);
  assign x.data   = x.vld ? mem[rd_ptr] : '0;

  assign push  = push_vld && push_rdy;
  assign pop   = x.vld && x.rdy;
  assign stall = x.vld && !x.rdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Clear wins over any increment landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        sent_cnt <= sent_cnt + 1'b1;
      end
      if (stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_data_stable: assert property (@(posedge clk) disable iff (rst)
    (x.vld && !x.rdy) |=> (x.vld && $stable(x.data)));

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (level == FULL_LVL)));

  a_level_range: assert property (@(posedge clk) disable iff (rst)
    level <= FULL_LVL);
`endif

endmodule

// File: doc/rdy_vld_src_fifo.md
Name: rdy_vld_src_fifo

Overview:
- Transmit-side endpoint for the rdy_vld_if protocol: the source that feeds a destination block sitting on the same interface.
- A local producer pushes words into an internal FIFO. The block drains the FIFO onto the interface under ready/valid flow control and keeps transfer and stall statistics for debug.
- Sits next to destination consumers in the hierInclude hierarchy and is instantiated by the parent block that owns the interface instance.

Parameters:
- DATA_W, 32, payload width; must equal the width of the interface data field.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- x  rdy_vld_if.src  -  outbound interface; drives x.vld and x.data, samples x.rdy.
- push_vld  input  1  producer offers a word.
- push_data  input  DATA_W  producer word.
- push_rdy  output  1  FIFO can accept a word this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- sent_cnt  output  CNT_W  completed interface transfers.
- stall_cnt  output  CNT_W  cycles with x.vld=1 and x.rdy=0.
- clr_stats  input  1  synchronous clear of both counters.

Behaviour:
- Reset: clock is clk; reset is rst, synchronous, active-high.
  - On reset: rd/wr pointers=0, level=0, x.vld=0, x.data=0, push_rdy=1, sent_cnt=0, stall_cnt=0.
  - A reset mid-transfer discards all buffered words; the interface drops vld with no completion.
- Push:
  - A word is accepted when push_vld && push_rdy.
  - push_rdy = (level != DEPTH), purely from registered state.
  - No full-bypass: when full, push_rdy=0 even if a pop occurs in the same cycle.
- Output:
  - x.vld = (level != 0); x.data = mem[rd_ptr], first-word-fall-through.
  - Latency: a word pushed at edge N into an empty FIFO appears on x at cycle N+1.
- Transfer: completes on a cycle with x.vld && x.rdy; on that edge rd_ptr advances.
- Source obligations:
  - Once x.vld=1, it stays 1 and x.data stays stable until the transfer completes.
  - vld never depends combinationally on x.rdy.
  - x.rdy=1 while x.vld=0 has no effect.
- Simultaneous push and pop: level is unchanged, both pointers advance.
  - Applies at any non-empty, non-full level.
  - At level 0, only the push occurs, since there is nothing to pop.
- Level updates: level +1 on push only; -1 on pop only. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- sent_cnt: +1 per completed transfer; wraps 2^CNT_W-1 -> 0.
- stall_cnt: +1 per cycle with x.vld && !x.rdy; wraps the same way.
- clr_stats:
  - Zeroes both counters on the next edge.
  - Has priority over any increment in the same cycle.
  - Does not touch the FIFO.
- Assertions required in RTL:
  - x.data stable while x.vld && !x.rdy.
  - No push accepted when level==DEPTH.
  - level <= DEPTH.

Test Plan:
- Reset then push 0xA5 with x.rdy=1:
  - x.vld=1, x.data=0xA5 one cycle after the push edge.
  - Transfer completes; sent_cnt=1, level returns to 0.
- x.rdy=0, push 4 words 0x1..0x4 (DEPTH=4):
  - push_rdy drops to 0 after the 4th push; level=4.
  - x.data holds 0x1 for 10 cycles; stall_cnt=10.
  - Raise x.rdy: outputs 0x1,0x2,0x3,0x4 on consecutive cycles.
- Full FIFO, x.rdy=1 and push_vld=1 in the same cycle:
  - Pop occurs, push is rejected (push_rdy=0); level becomes 3.
  - The next cycle accepts the push.
- Continuous push with x.rdy=1 at level 2:
  - Level stays 2 for 20 cycles.
  - Output sequence is in order with no gaps; sent_cnt=20.
- Random x.rdy (50%) with 1000 random pushes:
  - Scoreboard matches order and data exactly.
  - sent_cnt=1000; stability assertion never fires.
- Counter wrap and clear:
  - With CNT_W=4, 17 transfers -> sent_cnt=1.
  - clr_stats in the same cycle as a transfer -> sent_cnt=0.
  - rst asserted with level=3 -> x.vld=0 and level=0 on the next cycle.
